// File: rtl/link_pkg.sv
// Shared constants and state encoding for the serial-link arbitration blocks.
package link_pkg;

  localparam int LINK_WIDTH      = 25;
  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/emitter_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import link_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       valid
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;
  logic [IDX_W-1:0]     offset;
  logic [IDX_W:0]       sum;

  // Rotating the request vector so ptr lands at bit 0 turns the wrap-around
  // search into a plain lowest-set-bit search.
  always_comb begin
    doubled = {req, req} >> ptr;
    rotated = doubled[NUM_REQ-1:0];
    offset  = '0;
    valid   = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = i[IDX_W-1:0];
        valid  = 1'b1;
      end
    end
    sum    = {1'b0, ptr} + {1'b0, offset};
    winner = (sum >= NUM_REQ_W) ? IDX_W'(sum - NUM_REQ_W) : IDX_W'(sum);
  end

endmodule

// File: rtl/emitter_arbiter.sv
// Round-robin arbiter sharing one serial emitter among NUM_REQ requesters,
// sequencing the start/done handshake with a timeout abort.
module emitter_arbiter
  import link_pkg::*;
#(
  parameter int WIDTH   = LINK_WIDTH,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                       fast_clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         err,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [WIDTH-1:0]           em_data,
  output logic                       em_start,
  input  logic                       em_done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  arb_state_t         state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   grant_reg, grant_next;
  logic [WIDTH-1:0]   data_reg, data_next;
  logic               start_reg, start_next;
  logic [NUM_REQ-1:0] ack_reg, ack_next;
  logic [NUM_REQ-1:0] err_reg, err_next;
  logic               busy_reg, busy_next;

  logic [WIDTH-1:0]   words [NUM_REQ];
  logic [IDX_W-1:0]   pick_winner;
  logic               pick_valid;
  logic [IDX_W-1:0]   grant_inc;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
    assign words[gi] = req_data[gi*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .winner(pick_winner),
    .valid (pick_valid)
  );

  assign grant_inc = (grant_reg == IDX_LAST) ? '0 : grant_reg + 1'b1;

  always_ff @(posedge fast_clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      grant_reg <= '0;
      data_reg  <= '0;
      start_reg <= 1'b0;
      ack_reg   <= '0;
      err_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      data_reg  <= data_next;
      start_reg <= start_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    data_next  = data_reg;
    start_next = start_reg;
    ack_next   = '0;
    err_next   = '0;

    unique case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grant_next = pick_winner;
          data_next  = words[pick_winner];
          start_next = 1'b1;
          cnt_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        cnt_next = cnt_reg + 1'b1;
        // Done is checked first so a completion on the last allowed cycle acks.
        if (em_done) begin
          start_next          = 1'b0;
          ack_next[grant_reg] = 1'b1;
          ptr_next            = grant_inc;
          state_next          = RELEASE;
        end else if (cnt_reg == CNT_LAST) begin
          start_next          = 1'b0;
          err_next[grant_reg] = 1'b1;
          ptr_next            = grant_inc;
          state_next          = RELEASE;
        end
      end
      RELEASE: begin
        if (!em_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  assign ack      = ack_reg;
  assign err      = err_reg;
  assign busy     = busy_reg;
  assign grant_id = grant_reg;
  assign em_data  = data_reg;
  assign em_start = start_reg;

endmodule

// File: tb/tb_emitter_arbiter.sv
// Randomized self-checking bench for emitter_arbiter with a behavioural emitter
// and an arbitration/timing reference model.
module tb_emitter_arbiter;

  localparam int W  = 25;
  localparam int N  = 4;
  localparam int TO = 64;

  logic           fast_clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ack;
  logic [N-1:0]   err;
  logic           busy;
  logic [1:0]     grant_id;
  logic [W-1:0]   em_data;
  logic           em_start;
  logic           em_done;

  int vectors     = 0;
  int miscompares = 0;
  int exp_ptr     = 0;
  int em_delay    = 26;
  bit em_mute     = 0;
  int em_cnt      = 0;

  emitter_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .fast_clk(fast_clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack), .err(err), .busy(busy), .grant_id(grant_id),
    .em_data(em_data), .em_start(em_start), .em_done(em_done)
  );

  initial begin
    fast_clk = 0;
    forever #5 fast_clk = ~fast_clk;
  end

  // Emitter model: done rises em_delay cycles after start, falls once start drops.
  initial begin
    em_done = 0;
    forever begin
      @(posedge fast_clk);
      #1;
      if (em_start === 1'b1) begin
        em_cnt++;
        if (!em_mute && em_cnt >= em_delay) em_done = 1;
      end else begin
        em_cnt  = 0;
        em_done = 0;
      end
    end
  end

  function automatic int model_pick(input logic [N-1:0] r, input int ptr);
    for (int off = 0; off < N; off++) begin
      if (r[(ptr + off) % N]) return (ptr + off) % N;
    end
    return -1;
  endfunction

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  task automatic do_reset();
    reset = 1;
    req   = '0;
    repeat (2) @(negedge fast_clk);
    reset   = 0;
    exp_ptr = 0;
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge where IDLE is visible again.
  task automatic run_txn(input logic [N-1:0] r, input logic [N*W-1:0] d, input int delay,
                         input bit mute, input bit drop, input bit mid_drop, output int got_id);
    int win, e, ack_n, err_n, ack_k, err_k, start_bad;
    logic [N-1:0] ack_v, err_v, exp_oh;
    bit exp_ack;
    win      = model_pick(r, exp_ptr);
    exp_oh   = N'(1) << win;
    exp_ack  = !mute && (delay <= TO);
    e        = exp_ack ? delay : TO;
    em_delay = delay;
    em_mute  = mute;
    req      = r;
    req_data = d;
    @(posedge fast_clk);
    @(negedge fast_clk);
    got_id = int'(grant_id);
    vectors++;
    if (em_start !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL grant_start: em_start=%b busy=%b, required 1 1", em_start, busy);
    end
    vectors++;
    if (grant_id !== 2'(win)) begin
      miscompares++;
      $display("FAIL grant_id: got %0d, required %0d (req=%b ptr=%0d)", grant_id, win, r, exp_ptr);
    end
    vectors++;
    if (em_data !== d[win*W +: W]) begin
      miscompares++;
      $display("FAIL em_data: got %h, required %h", em_data, d[win*W +: W]);
    end
    vectors++;
    if (ack !== '0 || err !== '0) begin
      miscompares++;
      $display("FAIL early_pulse: ack=%b err=%b at grant, required 0 0", ack, err);
    end
    req_data = rand_data();
    ack_n = 0; err_n = 0; ack_k = -1; err_k = -1; start_bad = 0;
    ack_v = '0; err_v = '0;
    for (int k = 1; k <= e + 1; k++) begin
      @(posedge fast_clk);
      @(negedge fast_clk);
      if (ack !== '0) begin ack_n++; ack_k = k; ack_v = ack; end
      if (err !== '0) begin err_n++; err_k = k; err_v = err; end
      if (em_start !== (k < e)) start_bad++;
      if (mid_drop && k == 2 && k < e) req = '0;
      if (drop && k == e) req[win] = 1'b0;
      if (k == e + 1) begin
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL busy_drop: busy=%b one cycle after result, required 0", busy);
        end
      end
    end
    vectors++;
    if (start_bad != 0) begin
      miscompares++;
      $display("FAIL em_start_window: %0d bad cycles, required 0", start_bad);
    end
    vectors++;
    if (exp_ack ? (ack_n != 1 || err_n != 0) : (err_n != 1 || ack_n != 0)) begin
      miscompares++;
      $display("FAIL result_kind: ack pulses %0d err pulses %0d, required %0d %0d",
               ack_n, err_n, exp_ack ? 1 : 0, exp_ack ? 0 : 1);
    end
    vectors++;
    if ((exp_ack ? ack_k : err_k) != e || (exp_ack ? ack_v : err_v) !== exp_oh) begin
      miscompares++;
      $display("FAIL result_pulse: cycle %0d value %b, required cycle %0d value %b",
               exp_ack ? ack_k : err_k, exp_ack ? ack_v : err_v, e, exp_oh);
    end
    exp_ptr = (win + 1) % N;
    $display("txn req=%b grant=%0d delay=%0d mute=%0b expect=%s at cycle %0d",
             r, got_id, delay, mute, exp_ack ? "ack" : "err", e);
  endtask

  task automatic test_reset();
    reset    = 1;
    req      = '0;
    req_data = '0;
    repeat (3) @(posedge fast_clk);
    @(negedge fast_clk);
    vectors++;
    if ({ack, err, busy, grant_id, em_data, em_start} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: ack=%b err=%b busy=%b grant=%0d data=%h start=%b, required all 0",
               ack, err, busy, grant_id, em_data, em_start);
    end
    reset   = 0;
    exp_ptr = 0;
  endtask

  task automatic test_single();
    logic [N*W-1:0] d;
    int id;
    d = rand_data();
    d[0 +: W] = 25'd69420;
    run_txn(4'b0001, d, 26, 0, 1, 0, id);
    vectors++;
    if (id != 0) begin
      miscompares++;
      $display("FAIL single_grant: got %0d, required 0", id);
    end
  endtask

  task automatic test_contention();
    logic [N*W-1:0] d;
    int ids [5];
    int exp_order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    d = {25'd69, 25'd3461, 25'd0, 25'h1FF_FFFF};
    for (int i = 0; i < 5; i++) run_txn(4'b1111, d, 26, 0, 0, 0, ids[i]);
    req = '0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (ids[i] != exp_order[i]) begin
        miscompares++;
        $display("FAIL contention_order[%0d]: got %0d, required %0d", i, ids[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_fairness();
    int id;
    run_txn(4'b0010, rand_data(), 26, 0, 1, 0, id);
    run_txn(4'b0011, rand_data(), 26, 0, 1, 0, id);
    vectors++;
    if (id != 0) begin
      miscompares++;
      $display("FAIL fairness: got %0d, required 0 after grant to 1", id);
    end
  endtask

  task automatic test_timeout();
    int id;
    run_txn(4'b0100, rand_data(), 26, 1, 1, 0, id);
    em_mute = 0;
  endtask

  task automatic test_done_at_timeout();
    int id;
    run_txn(4'b1000, rand_data(), TO, 0, 1, 0, id);
  endtask

  task automatic test_reset_mid_send();
    int id, pulses;
    em_mute  = 1;
    req      = 4'b1000;
    req_data = rand_data();
    @(posedge fast_clk);
    repeat (10) @(posedge fast_clk);
    @(negedge fast_clk);
    reset = 1;
    req   = '0;
    @(posedge fast_clk);
    @(negedge fast_clk);
    vectors++;
    if ({ack, err, busy, grant_id, em_data, em_start} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_send: ack=%b err=%b busy=%b grant=%0d data=%h start=%b, required all 0",
               ack, err, busy, grant_id, em_data, em_start);
    end
    reset   = 0;
    exp_ptr = 0;
    em_mute = 0;
    pulses  = 0;
    repeat (3) begin
      @(negedge fast_clk);
      if (ack !== '0 || err !== '0) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL reset_no_pulse: %0d pulse cycles after reset, required 0", pulses);
    end
    run_txn(4'b1000, rand_data(), 26, 0, 1, 0, id);
  endtask

  task automatic test_random();
    int id;
    for (int i = 0; i < 40; i++) begin
      run_txn(N'($urandom_range(1, 15)), rand_data(), $urandom_range(1, TO + 6),
              ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), id);
      req = '0;
      repeat ($urandom_range(0, 2)) @(negedge fast_clk);
    end
  endtask

  initial begin
    reset    = 1;
    req      = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_timeout();
    test_done_at_timeout();
    test_reset_mid_send();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
